// File: rtl/xorshift_pkg.sv
// Shared definitions for the xorshift32 draw path: controller states, shift amounts
// and the single-step next-state function.
package xorshift_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    WARMUP = 2'd1,
    IDLE   = 2'd2
  } state_t;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  function automatic logic [31:0] xs32_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << XS_A);
    t = t ^ (t >> XS_B);
    t = t ^ (t << XS_C);
    return t;
  endfunction

endpackage

// File: rtl/xorshift32_core.sv
// 32-bit xorshift generator state; load has priority over step.
module xorshift32_core
  import xorshift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state,
  output logic [31:0] next
);

  assign next = xs32_next(state);

  always_ff @(posedge clk) begin
    if (rst)       state <= '0;
    else if (load) state <= load_val;
    else if (step) state <= next;
  end

endmodule

// File: rtl/xorshift_draw_arbiter.sv
// Seeds and warms up the xorshift32 core, then shares draws between requesters A and B
// with round-robin priority and a minimum grant-to-grant spacing.
module xorshift_draw_arbiter
  import xorshift_pkg::*;
#(
  parameter int          MAX_COUNT    = 100,
  parameter int          WARMUP_STEPS = 16,
  parameter logic [25:0] SEED_FILL    = 26'h155_5555
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seed,
  input  logic        reseed,
  input  logic        req_a,
  input  logic        req_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [31:0] rnd,
  output logic        busy
);

  localparam int WW = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
  localparam int GW = $clog2(MAX_COUNT);
  localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP_STEPS);
  localparam logic [GW-1:0] GAP_INIT  = GW'(MAX_COUNT - 1);

  state_t        st;
  logic [WW-1:0] warm_cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_b;
  logic          grant, pick_a, load, step;
  logic [31:0]   xs_state_unused, xs_next;

  // reseed in IDLE wins over an otherwise eligible grant
  assign grant  = (st == IDLE) && !reseed && (req_a || req_b) && (gap_cnt == '0);
  assign pick_a = req_a && (!req_b || last_b);
  assign load   = (st == SEED);
  assign step   = (st == WARMUP) || grant;
  assign busy   = (st != IDLE);

  xorshift32_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val ({seed, SEED_FILL}),
    .step     (step),
    .state    (xs_state_unused),
    .next     (xs_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= SEED;
      warm_cnt <= '0;
      gap_cnt  <= '0;
      last_b   <= 1'b1;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rnd      <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (grant) begin
        ack_a   <= pick_a;
        ack_b   <= !pick_a;
        rnd     <= xs_next;
        last_b  <= !pick_a;
        gap_cnt <= GAP_INIT;
      end
      unique case (st)
        SEED: begin
          warm_cnt <= WARM_INIT;
          st       <= (WARMUP_STEPS == 0) ? IDLE : WARMUP;
        end
        WARMUP: begin
          if (reseed) st <= SEED;
          else begin
            warm_cnt <= warm_cnt - 1'b1;
            if (warm_cnt == WW'(1)) st <= IDLE;
          end
        end
        IDLE:    if (reseed) st <= SEED;
        default: st <= SEED;
      endcase
    end
  end

endmodule
